// File: rtl/cosine_pkg.sv
// Shared types and width helpers for the cosine similarity engine.
package cosine_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StSqrt,
        StDiv,
        StDone
    } cos_state_t;

    // Width of the dot product and of each squared norm: 2W + clog2(N).
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/cosine_sim_engine_isqrt.sv
// Iterative integer square root: one root bit per cycle, RW/2 cycles per operation.
// The first root bit is produced on the start edge itself, so the root is final
// RW/2 edges after start; valid then stays high until the next start.
module isqrt_iter #(
    parameter int unsigned RW = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RW-1:0]     radicand,
    output logic [RW/2-1:0]   root,
    output logic              valid
);

    localparam int unsigned HW = RW / 2;
    localparam int unsigned CW = $clog2(HW + 1);

    logic [RW-1:0] rad_q, rad_d, src_rad;
    logic [HW+1:0] rem_q, rem_d, src_rem;
    logic [HW-1:0] root_q, root_d, src_root;
    logic [CW-1:0] cnt_q;
    logic          run_q, valid_q;
    logic [HW+3:0] try_val, trial;
    logic          ge, step;

    // One digit-by-digit step; on start the step works from the fresh radicand.
    always_comb begin
        src_rad  = start ? radicand : rad_q;
        src_rem  = start ? '0 : rem_q;
        src_root = start ? '0 : root_q;
        try_val  = {src_rem, src_rad[RW-1 -: 2]};
        trial    = {2'b00, src_root, 2'b01};
        ge       = (try_val >= trial);
        // The true difference fits in HW+2 bits, so the narrow subtract is exact.
        rem_d    = ge ? (try_val[HW+1:0] - trial[HW+1:0]) : try_val[HW+1:0];
        root_d   = {src_root[HW-2:0], ge};
        rad_d    = {src_rad[RW-3:0], 2'b00};
        step     = start | run_q;
    end

    // Iteration registers and step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (step) begin
                rad_q  <= rad_d;
                rem_q  <= rem_d;
                root_q <= root_d;
            end
            if (start) begin
                cnt_q   <= CW'(1);
                run_q   <= 1'b1;
                valid_q <= 1'b0;
            end else if (run_q) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(HW - 1)) begin
                    run_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign root  = root_q;
    assign valid = valid_q;

endmodule

// File: rtl/cosine_sim_engine.sv
// Sequential cosine similarity of two unsigned N-element vectors, result in Q1.FRAC.
// Optional zero-vector flag output enabled by defining COSINE_ZERO_FLAG_EN.
module cosine_sim_engine
    import cosine_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned FRAC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N*W-1:0]    a_vec,
    input  logic [N*W-1:0]    b_vec,
    output logic              busy,
    output logic              done,
    output logic [FRAC:0]     cos_q
`ifdef COSINE_ZERO_FLAG_EN
    ,
    output logic              zero_vec
`endif
);

    localparam int unsigned ACC  = acc_width(N, W);
    localparam int unsigned PADW = ACC - 2 * W;
    localparam int unsigned CW   = $clog2(N + ACC + FRAC + 2);
    localparam logic [FRAC:0] QONE = {1'b1, {FRAC{1'b0}}};

    cos_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N*W-1:0]    a_q, b_q;
    logic [ACC-1:0]    dot_q, na_q, nb_q;
    logic [ACC:0]      rem_q;
    logic [FRAC:0]     quo_q;
    logic              ovf_q;
    logic              done_q;

    logic [2*W-1:0]    p_ab, p_aa, p_bb;
    logic [2*ACC-1:0]  radicand;
    logic [ACC-1:0]    root;
    logic              sqrt_valid, sqrt_start;
    logic [ACC:0]      div_shift, div_rem;
    logic              div_ge, s_zero;
    logic [FRAC:0]     q_final;

    // Element products of the current MAC element (always the low element of the shift regs).
    always_comb begin
        p_ab       = {{W{1'b0}}, a_q[W-1:0]} * {{W{1'b0}}, b_q[W-1:0]};
        p_aa       = {{W{1'b0}}, a_q[W-1:0]} * {{W{1'b0}}, a_q[W-1:0]};
        p_bb       = {{W{1'b0}}, b_q[W-1:0]} * {{W{1'b0}}, b_q[W-1:0]};
        radicand   = {{ACC{1'b0}}, na_q} * {{ACC{1'b0}}, nb_q};
        sqrt_start = (state_q == StSqrt) && (cnt_q == '0);
    end

    isqrt_iter #(
        .RW (2 * ACC)
    ) u_isqrt (
        .clk      (clk),
        .reset    (reset),
        .start    (sqrt_start),
        .radicand (radicand),
        .root     (root),
        .valid    (sqrt_valid)
    );

    // Restoring division step; dot's LSB enters on the first step, zeros afterwards.
    always_comb begin
        div_shift = {rem_q[ACC-1:0], (cnt_q == '0) ? dot_q[0] : 1'b0};
        div_ge    = (div_shift >= {1'b0, root});
        div_rem   = div_ge ? (div_shift - {1'b0, root}) : div_shift;
        s_zero    = (root == '0);
        if (s_zero) begin
            q_final = '0;
        end else if (ovf_q || (quo_q > QONE)) begin
            q_final = QONE;
        end else begin
            q_final = quo_q;
        end
    end

    // Next-state logic: fixed-length phases timed by a shared counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) state_d = StLoad;
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StMac;
            end
            StMac: begin
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = StSqrt;
                end
            end
            StSqrt: begin
                if (cnt_q == CW'(ACC - 1)) begin
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                if (cnt_q == CW'(FRAC)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and phase counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath: operand latch, accumulation, division and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            dot_q  <= '0;
            na_q   <= '0;
            nb_q   <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            ovf_q  <= 1'b0;
            cos_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            unique case (state_q)
                StLoad: begin
                    a_q   <= a_vec;
                    b_q   <= b_vec;
                    dot_q <= '0;
                    na_q  <= '0;
                    nb_q  <= '0;
                end
                StMac: begin
                    a_q   <= a_q >> W;
                    b_q   <= b_q >> W;
                    dot_q <= dot_q + {{PADW{1'b0}}, p_ab};
                    na_q  <= na_q + {{PADW{1'b0}}, p_aa};
                    nb_q  <= nb_q + {{PADW{1'b0}}, p_bb};
                end
                StSqrt: begin
                    // Upper dividend bits above the first quotient position.
                    rem_q <= {2'b00, dot_q[ACC-1:1]};
                    quo_q <= '0;
                    ovf_q <= 1'b0;
                end
                StDiv: begin
                    if (sqrt_valid) begin
                        if (cnt_q == '0) ovf_q <= (rem_q >= {1'b0, root});
                        rem_q <= div_rem;
                        quo_q <= {quo_q[FRAC-1:0], div_ge};
                    end
                end
                StDone: begin
                    cos_q <= q_final;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef COSINE_ZERO_FLAG_EN
    logic zero_q;

    // Zero-norm flag captured alongside the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_q <= 1'b0;
        end else if (state_q == StDone) begin
            zero_q <= s_zero;
        end
    end

    assign zero_vec = zero_q;
`endif

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule
